// File: rtl/tcp_active_conn_manager.sv
// Client-side TCP connection sequencer: active open, sequence tracking, and active close through TIME_WAIT.
// Build option TCP_ISN_CLOCK_EN: when defined, the ISN comes from a free-running counter instead of the ISN parameter.
//
// state          | meaning
// IDLE (0)       | no connection, waiting for connect_req
// SYN_SENT (2)   | SYN sent, waiting for SYN+ACK, retransmit on timeout
// ESTABLISHED (3)| data phase, tracking local seq/ack
// FIN_WAIT_1 (4) | our FIN sent, waiting for its ACK and/or the peer FIN
// FIN_WAIT_2 (5) | our FIN acked, waiting for the peer FIN
// TIME_WAIT (8)  | dwell before returning to IDLE, re-ack retransmitted peer FIN
module tcp_active_conn_manager #(
    parameter logic [31:0] ISN              = 32'h0001_0000,
    parameter logic [31:0] SYN_RETRY_CYCLES = 32'd1_000_000,
    parameter logic [3:0]  MAX_RETRIES      = 4'd3,
    parameter logic [31:0] TIME_WAIT_CYCLES = 32'd2_000_000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        connect_req,
    input  logic        close_req,
    input  logic [31:0] dst_ip,
    input  logic [47:0] dst_mac,
    input  logic [15:0] dst_port,
    input  logic        rx_valid,
    input  logic        syn,
    input  logic        ack,
    input  logic        fin,
    input  logic        rst,
    input  logic [31:0] seq_number,
    input  logic [31:0] ack_number,
    input  logic [15:0] data_len,
    input  logic [15:0] tx_data_len,
    input  logic        tx_data_valid,
    output logic [31:0] seq_number_local,
    output logic [31:0] ack_number_local,
    output logic [31:0] tx_ip,
    output logic [47:0] tx_mac,
    output logic [15:0] tx_port,
    output logic        send_syn,
    output logic        send_ack,
    output logic        send_fin,
    output logic [3:0]  tcp_state,
    output logic        established_moment,
    output logic        conn_fail
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SYN_SENT = 4'd2,
        S_EST      = 4'd3,
        S_FW1      = 4'd4,
        S_FW2      = 4'd5,
        S_TW       = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] seq_q, seq_d, ack_q, ack_d;   // host byte order
    logic [31:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        fin_pend_q, fin_pend_d;
    logic        send_syn_d, send_ack_d, send_fin_d, est_d, fail_d;
    logic [31:0] tx_ip_d;
    logic [47:0] tx_mac_d;
    logic [15:0] tx_port_d;
    logic [31:0] isn_start;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [31:0] rx_seq_h, rx_ack_h, tx_len32;
    logic        rx_rst, seq_ok, timer_tc, retry_max;
    logic        synack_ok, fin_ok, ack_ok, fin_rtx;

    assign rx_seq_h  = bswap(seq_number);
    assign rx_ack_h  = bswap(ack_number);
    assign tx_len32  = tx_data_valid ? {16'd0, tx_data_len} : 32'd0;
    assign rx_rst    = rx_valid && rst;
    assign seq_ok    = (rx_seq_h == ack_q);
    assign timer_tc  = (timer_q == 32'd0);
    assign retry_max = (retry_q == MAX_RETRIES);
    assign synack_ok = rx_valid && syn && ack && (rx_ack_h == seq_q + 32'd1);
    assign fin_ok    = rx_valid && fin && seq_ok;
    assign ack_ok    = rx_valid && ack && (rx_ack_h == seq_q);
    assign fin_rtx   = rx_valid && fin && (rx_seq_h == ack_q - 32'd1);

`ifdef TCP_ISN_CLOCK_EN
    logic [31:0] isn_ctr;
    always_ff @(posedge aclk) begin
        if (!aresetn) isn_ctr <= ISN;
        else          isn_ctr <= isn_ctr + 32'd1;
    end
    assign isn_start = isn_ctr;
`else
    assign isn_start = ISN;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q            <= S_IDLE;
            seq_q              <= 32'd0;
            ack_q              <= 32'd0;
            timer_q            <= 32'd0;
            retry_q            <= 4'd0;
            fin_pend_q         <= 1'b0;
            tx_ip              <= 32'd0;
            tx_mac             <= 48'd0;
            tx_port            <= 16'd0;
            send_syn           <= 1'b0;
            send_ack           <= 1'b0;
            send_fin           <= 1'b0;
            established_moment <= 1'b0;
            conn_fail          <= 1'b0;
        end else begin
            state_q            <= state_d;
            seq_q              <= seq_d;
            ack_q              <= ack_d;
            timer_q            <= timer_d;
            retry_q            <= retry_d;
            fin_pend_q         <= fin_pend_d;
            tx_ip              <= tx_ip_d;
            tx_mac             <= tx_mac_d;
            tx_port            <= tx_port_d;
            send_syn           <= send_syn_d;
            send_ack           <= send_ack_d;
            send_fin           <= send_fin_d;
            established_moment <= est_d;
            conn_fail          <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && rx_rst) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (connect_req) state_d = S_SYN_SENT;
                S_SYN_SENT: begin
                    if (synack_ok)                   state_d = S_EST;
                    else if (timer_tc && retry_max)  state_d = S_IDLE;
                end
                S_EST: begin
                    if (fin_ok)         state_d = S_TW;
                    else if (close_req) state_d = S_FW1;
                end
                S_FW1: begin
                    if (fin_ok)                      state_d = S_TW;
                    else if (ack_ok)                 state_d = S_FW2;
                    else if (timer_tc && retry_max)  state_d = S_IDLE;
                end
                S_FW2:      if (fin_ok) state_d = S_TW;
                S_TW:       if (timer_tc && !fin_rtx) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        seq_d      = seq_q;
        ack_d      = ack_q;
        timer_d    = timer_tc ? 32'd0 : timer_q - 32'd1;
        retry_d    = retry_q;
        fin_pend_d = 1'b0;
        tx_ip_d    = tx_ip;
        tx_mac_d   = tx_mac;
        tx_port_d  = tx_port;
        send_syn_d = 1'b0;
        send_ack_d = 1'b0;
        send_fin_d = 1'b0;
        est_d      = 1'b0;
        fail_d     = 1'b0;
        if (state_q != S_IDLE && rx_rst) begin
            fail_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (connect_req) begin
                    tx_ip_d    = dst_ip;
                    tx_mac_d   = dst_mac;
                    tx_port_d  = dst_port;
                    seq_d      = isn_start;
                    ack_d      = 32'd0;
                    send_syn_d = 1'b1;
                    retry_d    = 4'd0;
                    timer_d    = SYN_RETRY_CYCLES - 32'd1;
                end
                S_SYN_SENT: begin
                    if (synack_ok) begin
                        seq_d      = seq_q + 32'd1;
                        ack_d      = rx_seq_h + 32'd1;
                        send_ack_d = 1'b1;
                        est_d      = 1'b1;
                    end else if (timer_tc) begin
                        if (retry_max) begin
                            fail_d = 1'b1;
                        end else begin
                            send_syn_d = 1'b1;
                            retry_d    = retry_q + 4'd1;
                            timer_d    = SYN_RETRY_CYCLES - 32'd1;
                        end
                    end
                end
                S_EST: begin
                    seq_d = seq_q + tx_len32;
                    if (fin_ok) begin
                        // ACK the peer FIN now, our own FIN goes out next cycle
                        ack_d      = ack_q + 32'd1;
                        send_ack_d = 1'b1;
                        fin_pend_d = 1'b1;
                        timer_d    = TIME_WAIT_CYCLES - 32'd1;
                    end else if (close_req) begin
                        seq_d      = seq_q + tx_len32 + 32'd1;
                        send_fin_d = 1'b1;
                        retry_d    = 4'd0;
                        timer_d    = SYN_RETRY_CYCLES - 32'd1;
                    end else if (rx_valid) begin
                        if (!seq_ok) begin
                            send_ack_d = 1'b1;
                        end else if (ack) begin
                            ack_d      = ack_q + {16'd0, data_len};
                            send_ack_d = (data_len != 16'd0);
                        end
                    end
                end
                S_FW1: begin
                    if (fin_ok) begin
                        ack_d      = ack_q + 32'd1;
                        send_ack_d = 1'b1;
                        timer_d    = TIME_WAIT_CYCLES - 32'd1;
                    end else if (!ack_ok && timer_tc) begin
                        if (retry_max) begin
                            fail_d = 1'b1;
                        end else begin
                            send_fin_d = 1'b1;
                            retry_d    = retry_q + 4'd1;
                            timer_d    = SYN_RETRY_CYCLES - 32'd1;
                        end
                    end
                end
                S_FW2: if (fin_ok) begin
                    ack_d      = ack_q + 32'd1;
                    send_ack_d = 1'b1;
                    timer_d    = TIME_WAIT_CYCLES - 32'd1;
                end
                S_TW: begin
                    if (fin_pend_q) begin
                        seq_d      = seq_q + 32'd1;
                        send_fin_d = 1'b1;
                    end else if (fin_rtx) begin
                        send_ack_d = 1'b1;
                        timer_d    = TIME_WAIT_CYCLES - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tcp_state        = state_q;
    assign seq_number_local = bswap(seq_q);
    assign ack_number_local = bswap(ack_q);

endmodule

// File: tb/tb_tcp_active_conn_manager.sv
// Randomized bench for tcp_active_conn_manager against a transaction-level connection model.
module tb_tcp_active_conn_manager;

    localparam logic [31:0] TB_ISN   = 32'h0001_0000;
    localparam logic [31:0] TB_ISN_W = 32'hFFFF_FFFF;
    localparam int          RETRY_N  = 100;
    localparam int          TW_N     = 200;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        connect_req = 1'b0, close_req = 1'b0;
    logic [31:0] dst_ip = '0;
    logic [47:0] dst_mac = '0;
    logic [15:0] dst_port = '0;
    logic        rx_valid = 1'b0, syn = 1'b0, ack = 1'b0, fin = 1'b0, rst = 1'b0;
    logic [31:0] seq_number = '0, ack_number = '0;
    logic [15:0] data_len = '0, tx_data_len = '0;
    logic        tx_data_valid = 1'b0;

    logic [31:0] seq_number_local, ack_number_local, tx_ip;
    logic [47:0] tx_mac;
    logic [15:0] tx_port;
    logic        send_syn, send_ack, send_fin, established_moment, conn_fail;
    logic [3:0]  tcp_state;

    logic [31:0] w_seq, w_ack, w_ip;
    logic [47:0] w_mac;
    logic [15:0] w_port;
    logic        w_syn, w_ack_p, w_fin, w_est, w_fail;
    logic [3:0]  w_state;

    tcp_active_conn_manager #(
        .ISN(TB_ISN), .SYN_RETRY_CYCLES(RETRY_N), .MAX_RETRIES(4'd3), .TIME_WAIT_CYCLES(TW_N)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .connect_req(connect_req), .close_req(close_req),
        .dst_ip(dst_ip), .dst_mac(dst_mac), .dst_port(dst_port),
        .rx_valid(rx_valid), .syn(syn), .ack(ack), .fin(fin), .rst(rst),
        .seq_number(seq_number), .ack_number(ack_number), .data_len(data_len),
        .tx_data_len(tx_data_len), .tx_data_valid(tx_data_valid),
        .seq_number_local(seq_number_local), .ack_number_local(ack_number_local),
        .tx_ip(tx_ip), .tx_mac(tx_mac), .tx_port(tx_port),
        .send_syn(send_syn), .send_ack(send_ack), .send_fin(send_fin),
        .tcp_state(tcp_state), .established_moment(established_moment), .conn_fail(conn_fail)
    );

    // second instance with an ISN at the top of the sequence space, shares all inputs
    tcp_active_conn_manager #(
        .ISN(TB_ISN_W), .SYN_RETRY_CYCLES(RETRY_N), .MAX_RETRIES(4'd3), .TIME_WAIT_CYCLES(TW_N)
    ) u_wrap (
        .aclk(aclk), .aresetn(aresetn), .connect_req(connect_req), .close_req(close_req),
        .dst_ip(dst_ip), .dst_mac(dst_mac), .dst_port(dst_port),
        .rx_valid(rx_valid), .syn(syn), .ack(ack), .fin(fin), .rst(rst),
        .seq_number(seq_number), .ack_number(ack_number), .data_len(data_len),
        .tx_data_len(tx_data_len), .tx_data_valid(tx_data_valid),
        .seq_number_local(w_seq), .ack_number_local(w_ack),
        .tx_ip(w_ip), .tx_mac(w_mac), .tx_port(w_port),
        .send_syn(w_syn), .send_ack(w_ack_p), .send_fin(w_fin),
        .tcp_state(w_state), .established_moment(w_est), .conn_fail(w_fail)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_err = 0;
    int n_syn = 0, n_ack = 0, n_fin = 0, n_est = 0, n_fail = 0, n_ovl = 0;
    int cyc = 0, fail_cyc = 0;
    int syn_q[$];
    logic [31:0] m_seq, m_ack;

    function automatic logic [31:0] nbo(input logic [31:0] h);
        return {h[7:0], h[15:8], h[23:16], h[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        if (send_syn) begin n_syn++; syn_q.push_back(cyc); end
        if (send_ack) n_ack++;
        if (send_fin) n_fin++;
        if (established_moment) n_est++;
        if (conn_fail) begin n_fail++; fail_cyc = cyc; end
        if (int'(send_syn) + int'(send_ack) + int'(send_fin) > 1) n_ovl++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rx_seg(input bit f_syn, input bit f_ack, input bit f_fin, input bit f_rst,
                          input logic [31:0] s_h, input logic [31:0] a_h, input logic [15:0] len);
        rx_valid = 1'b1; syn = f_syn; ack = f_ack; fin = f_fin; rst = f_rst;
        seq_number = nbo(s_h); ack_number = nbo(a_h); data_len = len;
        tick();
        rx_valid = 1'b0; syn = 1'b0; ack = 1'b0; fin = 1'b0; rst = 1'b0;
        seq_number = $urandom; ack_number = $urandom; data_len = 16'($urandom);
    endtask

    task automatic pulse_close();
        close_req = 1'b1;
        tick();
        close_req = 1'b0;
    endtask

    task automatic chk_conn(input string tag, input logic [3:0] st);
        chk({tag, "_state"}, tcp_state, st);
        chk({tag, "_seq"}, seq_number_local, nbo(m_seq));
        chk({tag, "_ack"}, ack_number_local, nbo(m_ack));
    endtask

    task automatic do_open(input logic [31:0] peer_isn, input logic [15:0] port, input bit sim_open);
        logic [31:0] e_ip;
        logic [47:0] e_mac;
        int s0, a0, e0;
        e_ip = $urandom; e_mac = {16'($urandom), 32'($urandom)};
        dst_ip = e_ip; dst_mac = e_mac; dst_port = port;
        s0 = n_syn;
        connect_req = 1'b1;
        tick();
        connect_req = 1'b0;
        dst_ip = $urandom; dst_mac = '0; dst_port = 16'($urandom);
        chk("open_syn", n_syn - s0, 1);
        m_seq = TB_ISN; m_ack = 32'd0;
        chk_conn("open", 4'd2);
        chk("open_ip", tx_ip, e_ip);
        chk("open_mac", tx_mac, e_mac);
        chk("open_port", tx_port, port);
        idle($urandom_range(1, 30));
        if (sim_open) begin
            a0 = n_ack;
            rx_seg(1, 0, 0, 0, peer_isn, 32'd0, 16'd0);
            chk("simopen_state", tcp_state, 4'd2);
            chk("simopen_noack", n_ack - a0, 0);
        end
        a0 = n_ack; e0 = n_est;
        rx_seg(1, 1, 0, 0, peer_isn, TB_ISN + 32'd1, 16'd0);
        m_seq = TB_ISN + 32'd1; m_ack = peer_isn + 32'd1;
        chk("est_pulse", n_est - e0, 1);
        chk("est_ack", n_ack - a0, 1);
        chk_conn("est", 4'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, len, off, a0, f0, s0, fl0, exp_ack;
        seq_number = '0; ack_number = '0;
        idle(2);
        chk("rst_state", tcp_state, 4'd0);
        chk("rst_seq", seq_number_local, 32'd0);
        chk("rst_ack", ack_number_local, 32'd0);
        chk("rst_addr", {tx_ip, tx_mac, tx_port}, 96'd0);
        chk("rst_pulses", {send_syn, send_ack, send_fin, established_moment, conn_fail}, 5'd0);
        aresetn = 1'b1;
        idle(2);

        // normal open with fixed peer ISN, then randomized data phase
        do_open(32'h0000_5000, 16'h1F90, 1'b1);
        for (int i = 0; i < 24; i++) begin
            op = (i < 3) ? i : int'($urandom_range(0, 2));
            a0 = n_ack;
            exp_ack = 0;
            case (op)
                0: begin
                    len = (i == 0) ? 1460 : int'($urandom_range(1, 1500));
                    tx_data_len = 16'(len); tx_data_valid = 1'b1;
                    tick();
                    tx_data_valid = 1'b0;
                    m_seq = m_seq + 32'(len);
                end
                1: begin
                    len = (i == 1) ? 100 : int'($urandom_range(0, 1460));
                    rx_seg(0, 1, 0, 0, m_ack, m_seq, 16'(len));
                    m_ack = m_ack + 32'(len);
                    exp_ack = (len != 0) ? 1 : 0;
                end
                default: begin
                    off = $urandom_range(1, 5000);
                    rx_seg(0, 1, 0, 0, m_ack + 32'(off), m_seq, 16'($urandom_range(1, 1460)));
                    exp_ack = 1;
                end
            endcase
            chk_conn("data", 4'd3);
            chk("data_ackpulse", n_ack - a0, exp_ack);
            idle($urandom_range(0, 3));
        end

        // active close with a same-cycle transmit
        len = $urandom_range(1, 1000);
        f0 = n_fin;
        tx_data_len = 16'(len); tx_data_valid = 1'b1;
        pulse_close();
        tx_data_valid = 1'b0;
        m_seq = m_seq + 32'(len) + 32'd1;
        chk("close_fin", n_fin - f0, 1);
        chk_conn("fw1", 4'd4);
        idle($urandom_range(1, 20));
        rx_seg(0, 1, 0, 0, m_ack, m_seq, 16'd0);
        chk_conn("fw2", 4'd5);
        a0 = n_ack;
        rx_seg(0, 1, 1, 0, m_ack, m_seq, 16'd0);
        m_ack = m_ack + 32'd1;
        chk("fw2_finack", n_ack - a0, 1);
        chk_conn("tw", 4'd8);
        idle($urandom_range(5, 100));
        a0 = n_ack;
        rx_seg(0, 1, 1, 0, m_ack - 32'd1, m_seq, 16'd0);
        chk("tw_reack", n_ack - a0, 1);
        idle(TW_N - 1);
        chk("tw_hold", tcp_state, 4'd8);
        tick();
        chk("tw_done", tcp_state, 4'd0);

        // peer-initiated close from ESTABLISHED: ACK then FIN
        do_open($urandom, 16'($urandom), 1'b0);
        a0 = n_ack; f0 = n_fin;
        rx_seg(0, 1, 1, 0, m_ack, m_seq, 16'd0);
        m_ack = m_ack + 32'd1;
        chk("pc_ack", n_ack - a0, 1);
        chk("pc_nofin", n_fin - f0, 0);
        chk_conn("pc", 4'd8);
        tick();
        m_seq = m_seq + 32'd1;
        chk("pc_fin", n_fin - f0, 1);
        chk_conn("pc_fin", 4'd8);
        idle(TW_N - 2);
        chk("pc_hold", tcp_state, 4'd8);
        tick();
        chk("pc_done", tcp_state, 4'd0);

        // FIN retransmit, simultaneous close, rst in TIME_WAIT
        do_open($urandom, 16'($urandom), 1'b0);
        f0 = n_fin;
        pulse_close();
        m_seq = m_seq + 32'd1;
        idle(RETRY_N - 1);
        chk("finrtx_wait", n_fin - f0, 1);
        tick();
        chk("finrtx", n_fin - f0, 2);
        chk_conn("finrtx", 4'd4);
        a0 = n_ack;
        rx_seg(0, 0, 1, 0, m_ack, 32'd0, 16'd0);
        m_ack = m_ack + 32'd1;
        chk("simclose_ack", n_ack - a0, 1);
        chk_conn("simclose", 4'd8);
        fl0 = n_fail;
        rx_seg(0, 0, 0, 1, $urandom, $urandom, 16'd0);
        chk("tw_rst_state", tcp_state, 4'd0);
        chk("tw_rst_fail", n_fail - fl0, 1);

        // rst in FIN_WAIT_2 wins over a same-cycle connect_req
        do_open($urandom, 16'($urandom), 1'b0);
        pulse_close();
        m_seq = m_seq + 32'd1;
        rx_seg(0, 1, 0, 0, m_ack, m_seq, 16'd0);
        chk_conn("fw2b", 4'd5);
        fl0 = n_fail; s0 = n_syn;
        connect_req = 1'b1;
        rx_seg(0, 0, 0, 1, $urandom, $urandom, 16'd0);
        connect_req = 1'b0;
        chk("fw2_rst_state", tcp_state, 4'd0);
        chk("fw2_rst_fail", n_fail - fl0, 1);
        tick();
        chk("fw2_rst_drop", n_syn - s0, 0);
        chk("fw2_rst_idle", tcp_state, 4'd0);

        // SYN retries exhausted
        syn_q.delete();
        s0 = n_syn; fl0 = n_fail;
        connect_req = 1'b1;
        tick();
        connect_req = 1'b0;
        for (int k = 0; k < 600 && tcp_state != 4'd0; k++) tick();
        chk("retry_syns", n_syn - s0, 4);
        chk("retry_fail", n_fail - fl0, 1);
        chk("retry_state", tcp_state, 4'd0);
        for (int i = 1; i < syn_q.size(); i++) chk("retry_gap", syn_q[i] - syn_q[i-1], RETRY_N);
        if (syn_q.size() > 0) chk("retry_failgap", fail_cyc - syn_q[syn_q.size()-1], RETRY_N);

        // reset asserted mid-handshake
        connect_req = 1'b1;
        tick();
        connect_req = 1'b0;
        idle(5);
        aresetn = 1'b0;
        tick();
        chk("mid_rst_state", tcp_state, 4'd0);
        chk("mid_rst_seqack", {seq_number_local, ack_number_local}, 64'd0);
        chk("mid_rst_addr", {tx_ip, tx_mac, tx_port}, 96'd0);
        aresetn = 1'b1;
        s0 = n_syn;
        idle(250);
        chk("mid_rst_nosyn", n_syn - s0, 0);
        chk("mid_rst_idle", tcp_state, 4'd0);

        // sequence-space wrap on the high-ISN instance
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        connect_req = 1'b1;
        tick();
        connect_req = 1'b0;
        chk("wrap_syn_seq", w_seq, nbo(TB_ISN_W));
        idle(3);
        rx_seg(1, 1, 0, 0, 32'hFFFF_FFEF, 32'h0000_0000, 16'd0);
        chk("wrap_state", w_state, 4'd3);
        chk("wrap_seq", w_seq, nbo(32'h0000_0000));
        chk("wrap_ack", w_ack, nbo(32'hFFFF_FFF0));
        chk("wrap_other", tcp_state, 4'd2);
        rx_seg(0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0000_0000, 16'd32);
        chk("wrap_data_ack", w_ack, nbo(32'h0000_0010));
        chk("wrap_data_pulse", w_ack_p, 1'b1);

        chk("no_overlap", n_ovl, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
